counter_sweep_ctrl: RTL and testbench
=====================================

# counter_sweep_ctrl

Sequencer for the 8-bit up/down counter. It drives the counter's reset, enable and direction inputs to run programmed sweeps: up to a target, down to a target, or repeated ping-pong passes between 0 and a target. The counter's output is fed back to decide when a sweep ends. The block sits directly beside the counter instance, and a higher-level test or control block operates it through a start/done handshake.

## Interface
- WIDTH, 8, counter width; `target` and `count_in` are this wide.
- REPEAT_W, 4, width of `repeats` and `passes_done`.

- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  sweep request; accepted only in IDLE.
- mode  in  2  sampled at accept:
  - 00: up to target
  - 01: down to target
  - 10: ping-pong
  - 11: reserved; start is ignored.
- target  in  WIDTH  end value; sampled at accept.
- repeats  in  REPEAT_W  ping-pong pass count; sampled at accept; 0 is treated as 1.
- pause  in  1  while high, counter is held (`ctr_enable` = 0); the FSM keeps its state.
- abort  in  1  terminates an active sweep without `done`.
- count_in  in  WIDTH  counter's current value (`counter_out` of the counter).
- ctr_rst  out  1  to counter `rst`.
- ctr_enable  out  1  to counter `enable`.
- ctr_dir  out  1  to counter `dir`; 1 = up.
- busy  out  1  high in CLEAR, UP and DOWN.
- done  out  1  one-cycle completion pulse.
- passes_done  out  REPEAT_W  completed ping-pong passes.

## Operation
- States: IDLE, CLEAR, UP, DOWN, DONE. The state register is the only source of the control outputs.
- Output decode (combinational from state, `pause`, `abort` and the compare):
  - `ctr_rst` = (state == CLEAR).
  - `ctr_dir` = (state == UP).
  - `ctr_enable` = 1 only in UP/DOWN, with `pause` = 0, `abort` = 0, and the state's end compare false.
  - `done` = (state == DONE).
- IDLE:
  - On `start` with `mode` != 11: latch `mode`, `target` and effective repeats (0→1); clear `passes_done`; go to CLEAR.
  - Otherwise stay.
- CLEAR: lasts one cycle. Next state is UP for modes 00/10, DOWN for mode 01.
- UP end compare is `count_in` == target_l:
  - mode 00 → DONE
  - mode 10 → DOWN
- DOWN end compare:
  - mode 01: `count_in` == target_l → DONE.
  - mode 10: `count_in` == 0 → increment `passes_done`; go to DONE if the new value equals repeats_l, else UP.
- DONE: lasts one cycle, then IDLE.
- The end compare is evaluated before enable, so the counter stops exactly on the end value; no overshoot.
- Mode 01 counts down from 0 and wraps: 0 → 2^WIDTH−1 → … → target.
- `abort` in CLEAR/UP/DOWN:
  - Next state IDLE, no `done`; `passes_done` holds.
  - Counter value is retained, except that `ctr_rst` still fires if abort arrives in CLEAR.
- `abort` has priority over `pause` and over the end compare.
- `start` while not in IDLE is ignored. Changes to `mode`, `target` or `repeats` after accept are ignored.
- `rst`:
  - Forces IDLE and `passes_done` = 0 at the next edge, with priority over all inputs; `start` in a reset cycle is ignored.
  - During and after reset, all outputs are 0.

## Timing
- `start` is sampled at edge N. CLEAR occupies cycle N+1 (`ctr_rst` high) and the counter reads 0 from cycle N+2. UP/DOWN begins at cycle N+2.
- Mode 00, target T: `count_in` = k at cycle N+2+k; end at N+2+T; `done` in cycle N+3+T.
- Mode 01, target T: `done` in cycle N+3+((2^WIDTH − T) mod 2^WIDTH).
- Mode 10, target T, R passes: each pass takes 2T+2 cycles; `done` in cycle N+2+R·(2T+2).
- Each paused cycle in UP/DOWN adds exactly one cycle to completion.
- `done` → IDLE in the next cycle. A new `start` is accepted one cycle after `done`.
- T = 0 in mode 00, and T = 0 in mode 01, each give `done` at N+3.

## Test plan
- Mode 00, T = 5, start at cycle N → `ctr_rst` high at N+1; `count_in` 0..5 over N+2..N+7; `done` pulse at N+8; counter holds 5 afterwards.
- Mode 10, T = 3, repeats = 2 → count sequence 0,1,2,3,3,2,1,0,0,1,2,3,3,2,1,0; `passes_done` goes 1 then 2; `done` at N+18.
- Mode 01, T = 250 → counter wraps 0 → 255 and stops at 250; `done` at N+9. Mode 11 start → no CLEAR, `busy` stays 0.
- Mode 00, T = 10, `pause` high for 3 cycles mid-sweep → counter frozen for those 3 cycles; `done` at N+16; final value 10.
- `abort` during UP at `count_in` = 4 → IDLE next cycle, no `done`, counter holds 4. `start` while `busy` → ignored.
- `rst` asserted mid ping-pong → all outputs 0 and `passes_done` = 0 next cycle. A `start` asserted together with `rst` is ignored. A fresh `start` after reset runs normally.

Source files
------------

// File: rtl/counter_sweep_ctrl_if.sv
// Control-side handshake between a test/control block and the sweep sequencer.
// The master starts sweeps and steers them; the slave reports progress.
interface counter_sweep_ctrl_if #(
    parameter int WIDTH    = 8,
    parameter int REPEAT_W = 4
);
    logic                start;
    logic [1:0]          mode;
    logic [WIDTH-1:0]    target;
    logic [REPEAT_W-1:0] repeats;
    logic                pause;
    logic                abort;
    logic                busy;
    logic                done;
    logic [REPEAT_W-1:0] passes_done;

    modport master (
        output start, mode, target, repeats, pause, abort,
        input  busy, done, passes_done
    );

    modport slave (
        input  start, mode, target, repeats, pause, abort,
        output busy, done, passes_done
    );
endinterface

// File: rtl/counter_sweep_ctrl.sv
// Sweep sequencer for an 8-bit up/down counter: runs up, down or ping-pong
// sweeps and uses the counter's fed-back value to stop exactly on the end value.
module counter_sweep_ctrl #(
    parameter int WIDTH    = 8,
    parameter int REPEAT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    counter_sweep_ctrl_if.slave  ctl,
    input  logic [WIDTH-1:0]     count_in,
    output logic                 ctr_rst,
    output logic                 ctr_enable,
    output logic                 ctr_dir
);

    localparam logic [1:0] MODE_UP       = 2'b00;
    localparam logic [1:0] MODE_DOWN     = 2'b01;
    localparam logic [1:0] MODE_PINGPONG = 2'b10;
    localparam logic [1:0] MODE_RSVD     = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        UP,
        DOWN,
        DONE
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [1:0]          mode_l;
    logic [1:0]          mode_next;
    logic [WIDTH-1:0]    target_l;
    logic [WIDTH-1:0]    target_next;
    logic [REPEAT_W-1:0] repeats_l;
    logic [REPEAT_W-1:0] repeats_next;
    logic [REPEAT_W-1:0] passes;
    logic [REPEAT_W-1:0] passes_next;
    logic [REPEAT_W-1:0] passes_inc;

    logic up_end;
    logic down_end;
    logic ctr_rst_c;
    logic ctr_enable_c;
    logic ctr_dir_c;
    logic busy_c;
    logic done_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mode_l    <= MODE_UP;
            target_l  <= '0;
            repeats_l <= '0;
            passes    <= '0;
        end else begin
            state     <= state_next;
            mode_l    <= mode_next;
            target_l  <= target_next;
            repeats_l <= repeats_next;
            passes    <= passes_next;
        end
    end

    // Ping-pong passes end on the way back down at zero; the other modes end at the target.
    assign up_end     = (count_in == target_l);
    assign down_end   = (mode_l == MODE_PINGPONG) ? (count_in == '0) : (count_in == target_l);
    assign passes_inc = passes + 1'b1;

    always_comb begin
        state_next   = state;
        mode_next    = mode_l;
        target_next  = target_l;
        repeats_next = repeats_l;
        passes_next  = passes;
        ctr_rst_c    = 1'b0;
        ctr_enable_c = 1'b0;
        ctr_dir_c    = 1'b0;
        busy_c       = 1'b0;
        done_c       = 1'b0;

        unique case (state)
            IDLE: begin
                if (ctl.start && (ctl.mode != MODE_RSVD)) begin
                    mode_next    = ctl.mode;
                    target_next  = ctl.target;
                    repeats_next = (ctl.repeats == '0) ? REPEAT_W'(1) : ctl.repeats;
                    passes_next  = '0;
                    state_next   = CLEAR;
                end
            end

            CLEAR: begin
                ctr_rst_c = 1'b1;
                busy_c    = 1'b1;
                if (ctl.abort) begin
                    state_next = IDLE;
                end else if (mode_l == MODE_DOWN) begin
                    state_next = DOWN;
                end else begin
                    state_next = UP;
                end
            end

            UP: begin
                busy_c       = 1'b1;
                ctr_dir_c    = 1'b1;
                ctr_enable_c = !ctl.pause && !ctl.abort && !up_end;
                if (ctl.abort) begin
                    state_next = IDLE;
                end else if (!ctl.pause && up_end) begin
                    state_next = (mode_l == MODE_UP) ? DONE : DOWN;
                end
            end

            DOWN: begin
                busy_c       = 1'b1;
                ctr_enable_c = !ctl.pause && !ctl.abort && !down_end;
                if (ctl.abort) begin
                    state_next = IDLE;
                end else if (!ctl.pause && down_end) begin
                    if (mode_l == MODE_PINGPONG) begin
                        passes_next = passes_inc;
                        state_next  = (passes_inc == repeats_l) ? DONE : UP;
                    end else begin
                        state_next = DONE;
                    end
                end
            end

            DONE: begin
                done_c     = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Reset is synchronous, so outputs are masked directly to keep them low during the reset cycle.
    assign ctr_rst         = ctr_rst_c & ~rst;
    assign ctr_enable      = ctr_enable_c & ~rst;
    assign ctr_dir         = ctr_dir_c & ~rst;
    assign ctl.busy        = busy_c & ~rst;
    assign ctl.done        = done_c & ~rst;
    assign ctl.passes_done = rst ? '0 : passes;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Directed bench for counter_sweep_ctrl with a behavioural 8-bit counter closing the loop
// and a queue of expected per-cycle observations built from the sweep timing.
module tb_counter_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       ctr_rst;
    logic       ctr_enable;
    logic       ctr_dir;
    logic [7:0] cnt = 8'd0;

    counter_sweep_ctrl_if #(.WIDTH(8), .REPEAT_W(4)) ctl ();

    counter_sweep_ctrl #(.WIDTH(8), .REPEAT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .ctl        (ctl),
        .count_in   (cnt),
        .ctr_rst    (ctr_rst),
        .ctr_enable (ctr_enable),
        .ctr_dir    (ctr_dir)
    );

    always #5 clk = ~clk;

    // Counter under control: reset wins, then enable with direction.
    always_ff @(posedge clk) begin
        if (ctr_rst) begin
            cnt <= 8'd0;
        end else if (ctr_enable) begin
            cnt <= ctr_dir ? cnt + 8'd1 : cnt - 8'd1;
        end
    end

    typedef struct {
        int rel;
        int cnt;
        bit chk_cnt;
        bit rst_e;
        bit busy;
        bit done;
        int passes;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   pause_lo, pause_hi, abort_at, start_at, rst_at;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic pushExp(input int rel, input int c, input bit chk, input bit r,
                           input bit b, input bit d, input int p);
        exp_t e;
        e.rel = rel; e.cnt = c; e.chk_cnt = chk; e.rst_e = r;
        e.busy = b; e.done = d; e.passes = p;
        sb.push_back(e);
    endtask

    task automatic trimAfter(input int lim);
        while (sb.size() > 0 && sb[sb.size()-1].rel > lim) sb.delete(sb.size()-1);
    endtask

    // Expected trace of an undisturbed sweep, from the cycle after acceptance to one idle cycle after done.
    task automatic pushSweep(input int m, input int t, input int r);
        int len, rr, per, base;
        pushExp(1, 0, 0, 1, 1, 0, 0);
        if (m == 0) begin
            for (int rel = 2; rel <= 2 + t; rel++) pushExp(rel, rel - 2, 1, 0, 1, 0, 0);
            pushExp(3 + t, t, 1, 0, 0, 1, 0);
            pushExp(4 + t, t, 1, 0, 0, 0, 0);
        end else if (m == 1) begin
            len = (256 - t) % 256;
            for (int k = 0; k <= len; k++) pushExp(2 + k, (256 - k) % 256, 1, 0, 1, 0, 0);
            pushExp(3 + len, t, 1, 0, 0, 1, 0);
            pushExp(4 + len, t, 1, 0, 0, 0, 0);
        end else begin
            rr  = (r == 0) ? 1 : r;
            per = 2 * t + 2;
            for (int p = 0; p < rr; p++) begin
                base = 2 + p * per;
                for (int k = 0; k <= t; k++) pushExp(base + k, k, 1, 0, 1, 0, p);
                for (int j = 0; j <= t; j++) pushExp(base + t + 1 + j, t - j, 1, 0, 1, 0, p);
            end
            pushExp(2 + rr * per, 0, 1, 0, 0, 1, rr);
            pushExp(3 + rr * per, 0, 1, 0, 0, 0, rr);
        end
    endtask

    task automatic clearKnobs();
        pause_lo = 0; pause_hi = -1; abort_at = -1; start_at = -1; rst_at = -1;
    endtask

    task automatic checkEntry(input string tag, input int rel);
        exp_t e;
        while (sb.size() > 0 && sb[0].rel == rel) begin
            e = sb.pop_front();
            if (e.chk_cnt) checkOutput($sformatf("%s r%0d count", tag, rel), int'(cnt), e.cnt);
            checkOutput($sformatf("%s r%0d ctr_rst", tag, rel), int'(ctr_rst), int'(e.rst_e));
            checkOutput($sformatf("%s r%0d busy", tag, rel), int'(ctl.busy), int'(e.busy));
            checkOutput($sformatf("%s r%0d done", tag, rel), int'(ctl.done), int'(e.done));
            checkOutput($sformatf("%s r%0d passes", tag, rel), int'(ctl.passes_done), e.passes);
        end
    endtask

    // Request a sweep, then scramble the request fields so only the latched copy can be used.
    task automatic applyStimulus(input string tag, input logic [1:0] m, input int t,
                                 input int r, input int len);
        @(negedge clk);
        ctl.start   = 1'b1;
        ctl.mode    = m;
        ctl.target  = 8'(t);
        ctl.repeats = 4'(r);
        for (int rel = 1; rel <= len; rel++) begin
            @(negedge clk);
            checkEntry(tag, rel);
            if (rel == 1) begin
                ctl.mode    = 2'b11;
                ctl.target  = ~ctl.target;
                ctl.repeats = ~ctl.repeats;
            end
            ctl.start = (rel == start_at);
            if (rel == start_at) begin
                ctl.mode   = 2'b00;
                ctl.target = 8'd9;
            end
            ctl.pause = (rel >= pause_lo && rel <= pause_hi);
            ctl.abort = (rel == abort_at);
            rst       = (rel == rst_at);
        end
        checkOutput({tag, " pending"}, sb.size(), 0);
        sb.delete();
        clearKnobs();
        ctl.start = 1'b0;
        ctl.pause = 1'b0;
        ctl.abort = 1'b0;
        rst       = 1'b0;
    endtask

    initial begin
        clearKnobs();
        rst         = 1'b1;
        ctl.start   = 1'b1;
        ctl.mode    = 2'b00;
        ctl.target  = 8'd3;
        ctl.repeats = 4'd1;
        ctl.pause   = 1'b0;
        ctl.abort   = 1'b0;

        repeat (2) begin
            @(negedge clk);
            checkOutput("reset busy", int'(ctl.busy), 0);
            checkOutput("reset done", int'(ctl.done), 0);
            checkOutput("reset ctr_rst", int'(ctr_rst), 0);
            checkOutput("reset ctr_enable", int'(ctr_enable), 0);
            checkOutput("reset ctr_dir", int'(ctr_dir), 0);
            checkOutput("reset passes", int'(ctl.passes_done), 0);
        end
        rst       = 1'b0;
        ctl.start = 1'b0;
        @(negedge clk);
        checkOutput("post-reset busy", int'(ctl.busy), 0);
        checkOutput("post-reset ctr_rst", int'(ctr_rst), 0);

        $display("[TB] up sweep to 5 with a start while busy");
        pushSweep(0, 5, 1);
        start_at = 4;
        applyStimulus("up5", 2'b00, 5, 1, 9);

        $display("[TB] ping-pong to 3, two passes");
        pushSweep(2, 3, 2);
        applyStimulus("pp3x2", 2'b10, 3, 2, 19);

        $display("[TB] down sweep to 250 through wrap");
        pushSweep(1, 250, 1);
        applyStimulus("down250", 2'b01, 250, 1, 10);

        $display("[TB] reserved mode start");
        for (int rel = 1; rel <= 3; rel++) pushExp(rel, 0, 0, 0, 0, 0, 0);
        applyStimulus("rsvd", 2'b11, 7, 1, 3);

        $display("[TB] zero targets");
        pushSweep(0, 0, 1);
        applyStimulus("up0", 2'b00, 0, 1, 4);
        pushSweep(1, 0, 1);
        applyStimulus("down0", 2'b01, 0, 1, 4);

        $display("[TB] up sweep to 10 with three paused cycles");
        pushExp(1, 0, 0, 1, 1, 0, 0);
        for (int rel = 2; rel <= 5; rel++)   pushExp(rel, rel - 2, 1, 0, 1, 0, 0);
        for (int rel = 6; rel <= 9; rel++)   pushExp(rel, 4, 1, 0, 1, 0, 0);
        for (int rel = 10; rel <= 15; rel++) pushExp(rel, rel - 5, 1, 0, 1, 0, 0);
        pushExp(16, 10, 1, 0, 0, 1, 0);
        pushExp(17, 10, 1, 0, 0, 0, 0);
        pause_lo = 6;
        pause_hi = 8;
        applyStimulus("pause10", 2'b00, 10, 1, 17);

        $display("[TB] abort during up sweep at count 4");
        pushSweep(0, 20, 1);
        trimAfter(6);
        for (int rel = 7; rel <= 9; rel++) pushExp(rel, 4, 1, 0, 0, 0, 0);
        abort_at = 6;
        applyStimulus("abort", 2'b00, 20, 1, 9);

        $display("[TB] ping-pong with zero repeats");
        pushSweep(2, 2, 0);
        applyStimulus("pp2x0", 2'b10, 2, 0, 9);

        $display("[TB] reset mid ping-pong with simultaneous start");
        pushSweep(2, 3, 3);
        trimAfter(12);
        pushExp(13, 2, 1, 0, 0, 0, 0);
        pushExp(14, 2, 1, 0, 0, 0, 0);
        rst_at   = 12;
        start_at = 12;
        applyStimulus("rstpp", 2'b10, 3, 3, 14);

        $display("[TB] fresh sweep after reset");
        pushSweep(0, 5, 1);
        applyStimulus("after_rst", 2'b00, 5, 1, 9);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
